scct_irq_ctrl: RTL and testbench
================================

Name: scct_irq_ctrl

Overview:
- Interrupt collector placed directly downstream of scct_counter and the scct_channel instances.
- Combines each source's interrupt status (istat/is) with its interrupt enable (ien) and selects one source by fixed priority.
- Presents a single irq line with a stable vector and runs a request/acknowledge handshake.
- On acknowledge, issues a one-cycle status-clear strobe to the served source; that strobe drives the source's isiw, with isi tied to 0.

Parameters:
NUM_CH, 4, number of scct_channel sources; total sources NSRC = NUM_CH+1.
VEC_WIDTH, 3, vector width; must satisfy 2**VEC_WIDTH >= NUM_CH+1.
CNT_WIDTH, 8, width of the served-interrupt counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  global interrupt enable.
src_is  input  NUM_CH+1  status levels; bit 0 = counter ct_istat, bit k = channel k-1 is.
src_ien  input  NUM_CH+1  enable levels, same bit mapping as src_is.
ack  input  1  single-cycle acknowledge pulse from the CPU side.
irq  output  1  interrupt request.
vec  output  VEC_WIDTH  index of the source being requested or served.
clr  output  NUM_CH+1  one-hot, one-cycle status-clear strobe.
busy  output  1  high in REQ and CLR states.
served_cnt  output  CNT_WIDTH  number of completed acknowledges, wrapping.

Behaviour:
- Reset (synchronous, dominant over all other inputs):
  - state=IDLE; irq=0, vec=0, clr=0, busy=0, served_cnt=0.
  - Reset asserted mid-handshake aborts the handshake with no clr strobe.
- pend = src_is & src_ien, combinational. Selected source = lowest set index of pend (counter highest priority, then channel 0, 1, ...).
- All outputs are registered.
- States: IDLE, REQ, CLR, SETTLE.
- IDLE:
  - If en=1 and pend!=0: vec <= selected index, irq <= 1, go to REQ. irq rises 1 cycle after pend and en are both true.
  - ack in IDLE is ignored.
- REQ:
  - vec stays frozen; new or higher-priority pend bits do not change it.
  - If pend[vec]=0 (software cleared or disabled the source) and ack=0: irq <= 0, go to IDLE. This is a retraction: no clr, no count.
  - If ack=1: irq <= 0, clr <= one-hot(vec) for exactly 1 cycle, served_cnt <= served_cnt+1 (wraps at 2**CNT_WIDTH), go to CLR. ack takes priority over a simultaneous retraction.
  - If en drops to 0 in REQ: irq <= 0, go to IDLE.
- CLR: clr <= 0, go to SETTLE. This state covers the one-cycle latency of the source's is register update.
- SETTLE: go to IDLE. Re-arbitration starts in IDLE, so a still-pending source (e.g., a new capture event arrived) re-raises irq.
- Timing and invariants:
  - ack-to-next-irq minimum spacing is 4 cycles.
  - busy = (state==REQ || state==CLR).
  - clr is never multi-hot.
  - clr is never asserted outside the cycle after an ack in REQ.
- Arithmetic: vec is the priority-encoder result zero-extended to VEC_WIDTH. Indices >= NSRC never appear.

Decomposition:
- Add to scct_constants.v:
  - state encodings SCCT_IRQ_IDLE=2'd0, SCCT_IRQ_REQ=2'd1, SCCT_IRQ_CLR=2'd2, SCCT_IRQ_SETTLE=2'd3;
  - SCCT_IRQ_SRC_CTR=0 (counter source index).
- One sub-module: scct_prio_enc. It is a parameterised lowest-index priority encoder with outputs valid and index.
- State machine and counter stay in scct_irq_ctrl.

Test Plan:
- Reset, then src_is=5'b00100, src_ien=5'b11111, en=1 → irq=1 one cycle later, vec=2. Pulse ack → next cycle clr=5'b00100 for 1 cycle, irq=0, served_cnt=1.
- src_is=5'b10011, all enabled → vec=0 first. After ack and source 0's is cleared: vec=1. Then vec=4. served_cnt=3. irq rises exactly 4 cycles after each ack.
- During REQ with vec=3, raise src_is[0] → vec stays 3 until ack. Then the next request has vec=0.
- In REQ with vec=2, drop src_is[2] with no ack → irq falls next cycle, clr stays 0, served_cnt unchanged. Same cycle ack=1 and src_is[2]=0 → clr=5'b00100 is issued and served_cnt increments.
- en=0 with pend!=0 → irq stays 0. ack pulses in IDLE → no clr. rst=1 during CLR → next cycle all outputs 0, state IDLE.
- Integrated with scct_counter and one scct_channel in input-capture any-edge mode:
  - an input edge sets is → irq rises with vec=1;
  - ack → clr drives isiw with isi=0 and the channel's is clears;
  - with CNT_WIDTH=8, served_cnt wraps 255→0 after 256 acks.

Source files
------------

// File: rtl/scct_irq_ctrl_pkg.sv
// Shared definitions for the scct interrupt collector.
// State encodings and fixed source indices.
package scct_irq_ctrl_pkg;

    typedef enum logic [1:0] {
        SCCT_IRQ_IDLE   = 2'd0,
        SCCT_IRQ_REQ    = 2'd1,
        SCCT_IRQ_CLR    = 2'd2,
        SCCT_IRQ_SETTLE = 2'd3
    } irq_state_e;

    localparam int SCCT_IRQ_SRC_CTR = 0;

endpackage

// File: rtl/scct_irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder.
// valid is high when any request bit is set.
module scct_prio_enc #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] index
);

    always_comb begin
        valid = |req;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = W'(i);
            end
        end
    end

endmodule

// File: rtl/scct_irq_ctrl.sv
// Interrupt collector: fixed-priority select, irq/ack handshake,
// one-cycle status-clear strobe and served-interrupt counter.
module scct_irq_ctrl
    import scct_irq_ctrl_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int VEC_WIDTH = 3,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NUM_CH:0]      src_is,
    input  logic [NUM_CH:0]      src_ien,
    input  logic                 ack,
    output logic                 irq,
    output logic [VEC_WIDTH-1:0] vec,
    output logic [NUM_CH:0]      clr,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] served_cnt
);

    localparam int NSRC = NUM_CH + 1;

    if ((2 ** VEC_WIDTH) < NSRC) begin : g_bad_width
        $error("VEC_WIDTH too small for NUM_CH+1 sources");
    end

    logic [NSRC-1:0]      pend;
    logic [NSRC-1:0]      vec_onehot;
    logic                 pend_hit;
    logic                 sel_valid;
    logic [VEC_WIDTH-1:0] sel_idx;

    irq_state_e           state_q;
    irq_state_e           state_d;
    logic                 irq_d;
    logic [VEC_WIDTH-1:0] vec_d;
    logic [NSRC-1:0]      clr_d;
    logic                 busy_d;
    logic [CNT_WIDTH-1:0] cnt_d;

    assign pend       = src_is & src_ien;
    assign vec_onehot = NSRC'(1) << vec;
    assign pend_hit   = |(pend & vec_onehot);

    scct_prio_enc #(
        .N (NSRC),
        .W (VEC_WIDTH)
    ) u_prio_enc (
        .req   (pend),
        .valid (sel_valid),
        .index (sel_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCCT_IRQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ack wins over a same-cycle retraction or enable drop
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SCCT_IRQ_IDLE: begin
                if (en && sel_valid) state_d = SCCT_IRQ_REQ;
            end
            SCCT_IRQ_REQ: begin
                if (ack)                  state_d = SCCT_IRQ_CLR;
                else if (!en || !pend_hit) state_d = SCCT_IRQ_IDLE;
            end
            SCCT_IRQ_CLR:    state_d = SCCT_IRQ_SETTLE;
            SCCT_IRQ_SETTLE: state_d = SCCT_IRQ_IDLE;
        endcase
    end

    always_comb begin
        irq_d  = 1'b0;
        vec_d  = vec;
        clr_d  = '0;
        cnt_d  = served_cnt;
        busy_d = (state_d == SCCT_IRQ_REQ) || (state_d == SCCT_IRQ_CLR);
        unique case (state_q)
            SCCT_IRQ_IDLE: begin
                if (state_d == SCCT_IRQ_REQ) begin
                    irq_d = 1'b1;
                    vec_d = sel_idx;
                end
            end
            SCCT_IRQ_REQ: begin
                irq_d = (state_d == SCCT_IRQ_REQ);
                if (state_d == SCCT_IRQ_CLR) begin
                    clr_d = vec_onehot;
                    cnt_d = served_cnt + CNT_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq        <= 1'b0;
            vec        <= '0;
            clr        <= '0;
            busy       <= 1'b0;
            served_cnt <= '0;
        end else begin
            irq        <= irq_d;
            vec        <= vec_d;
            clr        <= clr_d;
            busy       <= busy_d;
            served_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_scct_irq_ctrl.sv
// Scoreboard bench for scct_irq_ctrl: table-driven scenarios,
// a modelled capture channel as a source, and counter wrap.
module tb_scct_irq_ctrl;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic [4:0] is;
        logic [4:0] ien;
        logic       ack;
    } stim_t;

    typedef struct packed {
        logic       irq;
        logic [2:0] vec;
        logic [4:0] clr;
        logic       busy;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [4:0] src_is;
    logic [4:0] src_is_drv;
    logic [4:0] src_ien;
    logic       ack;
    logic       irq;
    logic [2:0] vec;
    logic [4:0] clr;
    logic       busy;
    logic [7:0] served_cnt;

    logic use_model;
    logic cap_in;
    logic cap_d;
    logic ch_is;

    int n_chk  = 0;
    int n_fail = 0;

    stim_t st[$];
    exp_t  ex[$];
    exp_t  sb[$];
    exp_t  e;
    exp_t  obs;

    always #5 clk = ~clk;

    // channel 0 model: any-edge capture sets is, isiw with isi=0 clears it
    always @(posedge clk) begin
        cap_d <= cap_in;
        if (rst)                 ch_is <= 1'b0;
        else if (clr[1])         ch_is <= 1'b0;
        else if (cap_in != cap_d) ch_is <= 1'b1;
    end

    assign src_is = use_model ? {3'b000, ch_is, 1'b0} : src_is_drv;

    scct_irq_ctrl #(
        .NUM_CH    (4),
        .VEC_WIDTH (3),
        .CNT_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .src_is     (src_is),
        .src_ien    (src_ien),
        .ack        (ack),
        .irq        (irq),
        .vec        (vec),
        .clr        (clr),
        .busy       (busy),
        .served_cnt (served_cnt)
    );

    function automatic stim_t s(logic r, logic n, logic [4:0] i,
                                logic [4:0] ie, logic a);
        return {r, n, i, ie, a};
    endfunction

    function automatic exp_t x(logic q, logic [2:0] v, logic [4:0] c,
                               logic b, logic [7:0] k);
        return {q, v, c, b, k};
    endfunction

    task automatic test_reset();
        st.delete(); ex.delete();
        st.push_back(s(1, 1, 5'h1f, 5'h1f, 1)); ex.push_back(x(0, 0, 0, 0, 0));
        st.push_back(s(1, 1, 5'h1f, 5'h1f, 1)); ex.push_back(x(0, 0, 0, 0, 0));
        foreach (st[i]) begin
            {rst, en, src_is_drv, src_ien, ack} = st[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            obs = {irq, vec, clr, busy, served_cnt};
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset[%0d] got=%h want=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_single();
        st.delete(); ex.delete();
        st.push_back(s(1, 0, 5'h00, 5'h1f, 0)); ex.push_back(x(0, 0, 0, 0, 0));
        st.push_back(s(0, 1, 5'h04, 5'h1f, 0)); ex.push_back(x(1, 2, 0, 1, 0));
        st.push_back(s(0, 1, 5'h04, 5'h1f, 1)); ex.push_back(x(0, 2, 5'h04, 1, 1));
        st.push_back(s(0, 1, 5'h00, 5'h1f, 0)); ex.push_back(x(0, 2, 0, 0, 1));
        st.push_back(s(0, 1, 5'h00, 5'h1f, 0)); ex.push_back(x(0, 2, 0, 0, 1));
        st.push_back(s(0, 1, 5'h00, 5'h1f, 0)); ex.push_back(x(0, 2, 0, 0, 1));
        foreach (st[i]) begin
            {rst, en, src_is_drv, src_ien, ack} = st[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            obs = {irq, vec, clr, busy, served_cnt};
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL single[%0d] got=%h want=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_priority();
        st.delete(); ex.delete();
        st.push_back(s(1, 0, 5'h00, 5'h1f, 0)); ex.push_back(x(0, 0, 0, 0, 0));
        st.push_back(s(0, 1, 5'h13, 5'h1f, 0)); ex.push_back(x(1, 0, 0, 1, 0));
        st.push_back(s(0, 1, 5'h13, 5'h1f, 1)); ex.push_back(x(0, 0, 5'h01, 1, 1));
        st.push_back(s(0, 1, 5'h12, 5'h1f, 0)); ex.push_back(x(0, 0, 0, 0, 1));
        st.push_back(s(0, 1, 5'h12, 5'h1f, 0)); ex.push_back(x(0, 0, 0, 0, 1));
        st.push_back(s(0, 1, 5'h12, 5'h1f, 0)); ex.push_back(x(1, 1, 0, 1, 1));
        st.push_back(s(0, 1, 5'h12, 5'h1f, 1)); ex.push_back(x(0, 1, 5'h02, 1, 2));
        st.push_back(s(0, 1, 5'h10, 5'h1f, 0)); ex.push_back(x(0, 1, 0, 0, 2));
        st.push_back(s(0, 1, 5'h10, 5'h1f, 0)); ex.push_back(x(0, 1, 0, 0, 2));
        st.push_back(s(0, 1, 5'h10, 5'h1f, 0)); ex.push_back(x(1, 4, 0, 1, 2));
        st.push_back(s(0, 1, 5'h10, 5'h1f, 1)); ex.push_back(x(0, 4, 5'h10, 1, 3));
        st.push_back(s(0, 1, 5'h00, 5'h1f, 0)); ex.push_back(x(0, 4, 0, 0, 3));
        foreach (st[i]) begin
            {rst, en, src_is_drv, src_ien, ack} = st[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            obs = {irq, vec, clr, busy, served_cnt};
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL priority[%0d] got=%h want=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_freeze();
        st.delete(); ex.delete();
        st.push_back(s(1, 0, 5'h00, 5'h1f, 0)); ex.push_back(x(0, 0, 0, 0, 0));
        st.push_back(s(0, 1, 5'h08, 5'h1f, 0)); ex.push_back(x(1, 3, 0, 1, 0));
        st.push_back(s(0, 1, 5'h09, 5'h1f, 0)); ex.push_back(x(1, 3, 0, 1, 0));
        st.push_back(s(0, 1, 5'h09, 5'h1f, 1)); ex.push_back(x(0, 3, 5'h08, 1, 1));
        st.push_back(s(0, 1, 5'h01, 5'h1f, 0)); ex.push_back(x(0, 3, 0, 0, 1));
        st.push_back(s(0, 1, 5'h01, 5'h1f, 0)); ex.push_back(x(0, 3, 0, 0, 1));
        st.push_back(s(0, 1, 5'h01, 5'h1f, 0)); ex.push_back(x(1, 0, 0, 1, 1));
        st.push_back(s(0, 1, 5'h01, 5'h1f, 1)); ex.push_back(x(0, 0, 5'h01, 1, 2));
        st.push_back(s(0, 1, 5'h00, 5'h1f, 0)); ex.push_back(x(0, 0, 0, 0, 2));
        foreach (st[i]) begin
            {rst, en, src_is_drv, src_ien, ack} = st[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            obs = {irq, vec, clr, busy, served_cnt};
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL freeze[%0d] got=%h want=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_retract();
        st.delete(); ex.delete();
        st.push_back(s(1, 0, 5'h00, 5'h1f, 0)); ex.push_back(x(0, 0, 0, 0, 0));
        st.push_back(s(0, 1, 5'h04, 5'h1f, 0)); ex.push_back(x(1, 2, 0, 1, 0));
        st.push_back(s(0, 1, 5'h00, 5'h1f, 0)); ex.push_back(x(0, 2, 0, 0, 0));
        st.push_back(s(0, 1, 5'h04, 5'h1f, 0)); ex.push_back(x(1, 2, 0, 1, 0));
        st.push_back(s(0, 1, 5'h00, 5'h1f, 1)); ex.push_back(x(0, 2, 5'h04, 1, 1));
        st.push_back(s(0, 1, 5'h00, 5'h1f, 0)); ex.push_back(x(0, 2, 0, 0, 1));
        st.push_back(s(0, 1, 5'h00, 5'h1f, 0)); ex.push_back(x(0, 2, 0, 0, 1));
        st.push_back(s(0, 1, 5'h04, 5'h1f, 0)); ex.push_back(x(1, 2, 0, 1, 1));
        st.push_back(s(0, 0, 5'h04, 5'h1f, 0)); ex.push_back(x(0, 2, 0, 0, 1));
        st.push_back(s(0, 0, 5'h04, 5'h1f, 0)); ex.push_back(x(0, 2, 0, 0, 1));
        st.push_back(s(0, 1, 5'h04, 5'h1b, 0)); ex.push_back(x(0, 2, 0, 0, 1));
        foreach (st[i]) begin
            {rst, en, src_is_drv, src_ien, ack} = st[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            obs = {irq, vec, clr, busy, served_cnt};
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL retract[%0d] got=%h want=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_idle_and_abort();
        st.delete(); ex.delete();
        st.push_back(s(1, 0, 5'h00, 5'h1f, 0)); ex.push_back(x(0, 0, 0, 0, 0));
        st.push_back(s(0, 0, 5'h1f, 5'h1f, 0)); ex.push_back(x(0, 0, 0, 0, 0));
        st.push_back(s(0, 0, 5'h1f, 5'h1f, 1)); ex.push_back(x(0, 0, 0, 0, 0));
        st.push_back(s(0, 1, 5'h1f, 5'h00, 1)); ex.push_back(x(0, 0, 0, 0, 0));
        st.push_back(s(0, 1, 5'h02, 5'h1f, 0)); ex.push_back(x(1, 1, 0, 1, 0));
        st.push_back(s(0, 1, 5'h02, 5'h1f, 1)); ex.push_back(x(0, 1, 5'h02, 1, 1));
        st.push_back(s(1, 1, 5'h02, 5'h1f, 0)); ex.push_back(x(0, 0, 0, 0, 0));
        st.push_back(s(0, 1, 5'h02, 5'h1f, 0)); ex.push_back(x(1, 1, 0, 1, 0));
        st.push_back(s(1, 1, 5'h02, 5'h1f, 1)); ex.push_back(x(0, 0, 0, 0, 0));
        foreach (st[i]) begin
            {rst, en, src_is_drv, src_ien, ack} = st[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            obs = {irq, vec, clr, busy, served_cnt};
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL idle_abort[%0d] got=%h want=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_channel();
        use_model = 1'b1;
        cap_in = 1'b0;
        rst = 1'b1; en = 1'b1; src_ien = 5'h1f; ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int pass = 0; pass < 2; pass++) begin
            cap_in = ~cap_in;
            sb.push_back(x(1, 1, 0, 1, 8'(pass)));
            for (int k = 0; k < 6 && irq !== 1'b1; k++) begin
                @(posedge clk); #1;
            end
            e = sb.pop_front();
            obs = {irq, vec, clr, busy, served_cnt};
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL chan_irq[%0d] got=%h want=%h", pass, obs, e);
            end
            ack = 1'b1;
            sb.push_back(x(0, 1, 5'h02, 1, 8'(pass + 1)));
            @(posedge clk); #1;
            ack = 1'b0;
            e = sb.pop_front();
            obs = {irq, vec, clr, busy, served_cnt};
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL chan_clr[%0d] got=%h want=%h", pass, obs, e);
            end
            repeat (4) @(posedge clk);
            #1;
            n_chk++;
            if (ch_is !== 1'b0 || irq !== 1'b0) begin
                n_fail++;
                $display("FAIL chan_quiet[%0d] got is=%b irq=%b want 0 0",
                         pass, ch_is, irq);
            end
        end
        use_model = 1'b0;
    endtask

    task automatic test_wrap();
        rst = 1'b1; en = 1'b1; src_is_drv = 5'h01; src_ien = 5'h1f; ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 8 && irq !== 1'b1; k++) begin
                @(posedge clk); #1;
            end
            ack = 1'b1;
            sb.push_back(x(0, 0, 5'h01, 1, 8'(i + 1)));
            @(posedge clk); #1;
            ack = 1'b0;
            e = sb.pop_front();
            obs = {irq, vec, clr, busy, served_cnt};
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL wrap[%0d] got=%h want=%h", i, obs, e);
            end
        end
        n_chk++;
        if (served_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_zero got=%0d want=0", served_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; src_is_drv = '0; src_ien = '0; ack = 1'b0;
        use_model = 1'b0; cap_in = 1'b0;
        #1;
        test_reset();
        test_single();
        test_priority();
        test_freeze();
        test_retract();
        test_idle_and_abort();
        test_channel();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
